// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low patterns (bit 0 = a .. bit 6 = g),
// reconstructed-digit codes and the scan reader's slot state.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  typedef enum logic {
    SETTLE = 1'b0,
    HOLD   = 1'b1
  } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Inverse of the BCD-to-segment encoder: maps an active-low segment pattern
// back to its BCD code; blank gives CODE_BLANK, anything else is flagged.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] code_o_c,
  output logic       err_o_c
);

  always_comb begin
    code_o_c = CODE_ERR;
    err_o_c  = 1'b0;
    case (pattern_i)
      SEG_0:     code_o_c = 4'd0;
      SEG_1:     code_o_c = 4'd1;
      SEG_2:     code_o_c = 4'd2;
      SEG_3:     code_o_c = 4'd3;
      SEG_4:     code_o_c = 4'd4;
      SEG_5:     code_o_c = 4'd5;
      SEG_6:     code_o_c = 4'd6;
      SEG_7:     code_o_c = 4'd7;
      SEG_8:     code_o_c = 4'd8;
      SEG_9:     code_o_c = 4'd9;
      SEG_BLANK: code_o_c = CODE_BLANK;
      default:   err_o_c  = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Snoops a multiplexed active-low 7-segment bus, captures each settled scan
// slot, decodes it back to BCD and publishes a frame once all digits are seen.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [6:0]                seg_n,
  input  logic [NUM_DIGITS-1:0]     dig_n,
  output logic [4*NUM_DIGITS-1:0]   digits,
  output logic [NUM_DIGITS-1:0]     digit_err,
  output logic                      frame_valid,
  output logic                      frame_err
);

  localparam int unsigned SMP_W = 7 + NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SMP_W-1:0]        meta_q, sync_q, prev_q;
  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic                    fv_q, fv_d;
  logic                    fe_q, fe_d;

  logic [6:0]              seg_s_c;
  logic [NUM_DIGITS-1:0]   sel_c, mask_set_c;
  logic                    changed_c, onehot_c;
  logic [3:0]              dec_code_c;
  logic                    dec_err_c;

  // Two-flop synchronisers plus the previous synchronised sample; idle bus is all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
      prev_q <= '1;
    end else begin
      meta_q <= {seg_n, dig_n};
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign seg_s_c   = sync_q[SMP_W-1:NUM_DIGITS];
  assign sel_c     = ~sync_q[NUM_DIGITS-1:0];
  assign changed_c = (sync_q != prev_q);
  assign onehot_c  = (sel_c != '0) && ((sel_c & (sel_c - NUM_DIGITS'(1))) == '0);

  seg7_pattern_decode u_decode (
    .pattern_i (seg_s_c),
    .code_o_c  (dec_code_c),
    .err_o_c   (dec_err_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SETTLE;
      cnt_q    <= '0;
      digits_q <= '1;
      err_q    <= '0;
      mask_q   <= '0;
      fv_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      err_q    <= err_d;
      mask_q   <= mask_d;
      fv_q     <= fv_d;
      fe_q     <= fe_d;
    end
  end

  // A change always restarts settling; capture needs a full stable run on a one-hot select.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    digits_d   = digits_q;
    err_d      = err_q;
    mask_d     = mask_q;
    fv_d       = 1'b0;
    fe_d       = 1'b0;
    mask_set_c = mask_q | sel_c;
    if (changed_c) begin
      state_d = SETTLE;
      cnt_d   = '0;
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (state_q == SETTLE && cnt_q == CNT_MAX && onehot_c) begin
        state_d = HOLD;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (sel_c[i]) begin
            digits_d[4*i +: 4] = dec_code_c;
            err_d[i]           = dec_err_c;
          end
        end
        if (mask_set_c == '1) begin
          fv_d   = 1'b1;
          fe_d   = |err_d;
          mask_d = '0;
        end else begin
          mask_d = mask_set_c;
        end
      end
    end
  end

  assign digits      = digits_q;
  assign digit_err   = err_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: directed scenarios plus random scan slots checked
// against a slot-level model (a slot counts only if long enough and one-hot).
module tb_seg7_scan_reader;

  localparam int S = 4;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        frame_err;

  seg7_scan_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .dig_n       (dig_n),
    .digits      (digits),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  // Slot-level reference state
  logic [3:0]  m_code [4];
  logic [3:0]  m_err;
  logic [3:0]  m_mask;
  int          m_frames = 0;
  logic [15:0] m_last_digits = 16'hFFFF;
  logic        m_last_fe = 1'b0;
  logic [6:0]  last_seg = 7'h7F;
  logic [3:0]  last_dig = 4'hF;

  // Observed frame pulses
  int          fv_cnt = 0;
  logic [15:0] obs_last_digits = 16'h0000;
  logic        obs_last_fe = 1'b0;

  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      fv_cnt          <= fv_cnt + 1;
      obs_last_digits <= digits;
      obs_last_fe     <= frame_err;
    end
  end

  function automatic logic [15:0] pack_digits();
    logic [15:0] p;
    for (int i = 0; i < 4; i++) p[4*i +: 4] = m_code[i];
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_code[i] = 4'hF;
    m_err  = 4'h0;
    m_mask = 4'h0;
  endtask

  task automatic ref_decode(input logic [6:0] seg, output logic [3:0] code, output logic e);
    code = 4'hE;
    e    = 1'b1;
    if (seg == 7'h7F) begin
      code = 4'hF;
      e    = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      if (seg == seg_tab[i]) begin
        code = 4'(i);
        e    = 1'b0;
      end
    end
  endtask

  task automatic model_slot(input logic [6:0] seg, input logic [3:0] dig, input int len);
    int idx;
    logic [3:0] code;
    logic e;
    logic [3:0] low;
    low = ~dig;
    if (len < S + 1 || $countones(low) != 1) return;
    idx = 0;
    for (int i = 0; i < 4; i++) if (low[i]) idx = i;
    ref_decode(seg, code, e);
    m_code[idx] = code;
    m_err[idx]  = e;
    m_mask[idx] = 1'b1;
    if (m_mask == 4'hF) begin
      m_frames++;
      m_last_digits = pack_digits();
      m_last_fe     = |m_err;
      m_mask        = 4'h0;
    end
  endtask

  // Present one scan slot for exactly len clock edges, starting at a falling edge.
  task automatic drive_slot(input logic [6:0] seg, input logic [3:0] dig, input int len);
    seg_n    = seg;
    dig_n    = dig;
    last_seg = seg;
    last_dig = dig;
    model_slot(seg, dig, len);
    repeat (len) @(negedge clk);
  endtask

  task automatic idle(input int len);
    drive_slot(7'h7F, 4'hF, len);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    seg_n = 7'h7F;
    dig_n = 4'hF;
    model_reset();
    repeat (3) @(negedge clk);
    total++;
    if (digits !== 16'hFFFF) begin
      bad++; $display("FAIL reset_digits got=%h want=%h", digits, 16'hFFFF);
    end
    total++;
    if (digit_err !== 4'h0) begin
      bad++; $display("FAIL reset_digit_err got=%b want=%b", digit_err, 4'h0);
    end
    total++;
    if (frame_valid !== 1'b0 || frame_err !== 1'b0) begin
      bad++; $display("FAIL reset_frame got=%b%b want=00", frame_valid, frame_err);
    end
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_clean_scan();
    int f0;
    f0 = fv_cnt;
    drive_slot(seg_tab[1], 4'b1110, 10);
    drive_slot(seg_tab[2], 4'b1101, 10);
    drive_slot(seg_tab[3], 4'b1011, 10);
    drive_slot(seg_tab[4], 4'b0111, 10);
    idle(8);
    total++;
    if (digits !== 16'h4321) begin
      bad++; $display("FAIL clean_digits got=%h want=%h", digits, 16'h4321);
    end
    total++;
    if (fv_cnt !== f0 + 1) begin
      bad++; $display("FAIL clean_frames got=%0d want=%0d", fv_cnt - f0, 1);
    end
    total++;
    if (obs_last_digits !== 16'h4321 || obs_last_fe !== 1'b0) begin
      bad++; $display("FAIL clean_frame_payload got=%h/%b want=4321/0", obs_last_digits, obs_last_fe);
    end
  endtask

  task automatic test_short_slot();
    int f0;
    f0 = fv_cnt;
    drive_slot(seg_tab[6], 4'b1110, S);
    drive_slot(seg_tab[1], 4'b1101, 10);
    drive_slot(seg_tab[2], 4'b1011, 10);
    drive_slot(seg_tab[3], 4'b0111, 10);
    idle(8);
    total++;
    if (fv_cnt !== f0) begin
      bad++; $display("FAIL short_no_frame got=%0d want=%0d", fv_cnt - f0, 0);
    end
    total++;
    if (digits !== 16'h3211) begin
      bad++; $display("FAIL short_digits got=%h want=%h", digits, 16'h3211);
    end
    drive_slot(seg_tab[6], 4'b1110, S + 1);
    idle(8);
    total++;
    if (fv_cnt !== f0 + 1 || obs_last_digits !== 16'h3216) begin
      bad++; $display("FAIL min_slot_frame got=%0d/%h want=1/3216", fv_cnt - f0, obs_last_digits);
    end
  endtask

  task automatic test_invalid_blank();
    int f0;
    f0 = fv_cnt;
    drive_slot(seg_tab[0], 4'b1110, 10);
    drive_slot(seg_tab[9], 4'b1101, 10);
    drive_slot(7'b1111111, 4'b1011, 10);
    drive_slot(7'b0101010, 4'b0111, 10);
    idle(8);
    total++;
    if (digits !== 16'hEF90) begin
      bad++; $display("FAIL inval_digits got=%h want=%h", digits, 16'hEF90);
    end
    total++;
    if (digit_err !== 4'b1000) begin
      bad++; $display("FAIL inval_digit_err got=%b want=%b", digit_err, 4'b1000);
    end
    total++;
    if (fv_cnt !== f0 + 1 || obs_last_fe !== 1'b1) begin
      bad++; $display("FAIL inval_frame_err got=%0d/%b want=1/1", fv_cnt - f0, obs_last_fe);
    end
  endtask

  task automatic test_bad_select();
    int f0;
    f0 = fv_cnt;
    drive_slot(seg_tab[8], 4'b0000, 20);
    drive_slot(seg_tab[5], 4'b1111, 20);
    idle(8);
    total++;
    if (digits !== 16'hEF90 || digit_err !== 4'b1000) begin
      bad++; $display("FAIL badsel_outputs got=%h/%b want=ef90/1000", digits, digit_err);
    end
    total++;
    if (fv_cnt !== f0) begin
      bad++; $display("FAIL badsel_frames got=%0d want=%0d", fv_cnt - f0, 0);
    end
  endtask

  task automatic test_recapture();
    int f0;
    f0 = fv_cnt;
    drive_slot(seg_tab[5], 4'b1110, 10);
    drive_slot(seg_tab[7], 4'b1110, 10);
    drive_slot(seg_tab[1], 4'b1101, 10);
    drive_slot(seg_tab[2], 4'b1011, 10);
    drive_slot(seg_tab[3], 4'b0111, 40);
    idle(8);
    total++;
    if (fv_cnt !== f0 + 1 || obs_last_digits !== 16'h3217 || obs_last_fe !== 1'b0) begin
      bad++; $display("FAIL recap_frame got=%0d/%h/%b want=1/3217/0", fv_cnt - f0, obs_last_digits, obs_last_fe);
    end
    drive_slot(seg_tab[4], 4'b1110, 10);
    drive_slot(seg_tab[4], 4'b1101, 10);
    drive_slot(seg_tab[4], 4'b1011, 10);
    idle(8);
    total++;
    if (fv_cnt !== f0 + 1) begin
      bad++; $display("FAIL hold_no_dup got=%0d want=%0d", fv_cnt - f0, 1);
    end
    drive_slot(seg_tab[9], 4'b0111, 10);
    idle(8);
    total++;
    if (fv_cnt !== f0 + 2 || obs_last_digits !== 16'h9444) begin
      bad++; $display("FAIL hold_next_frame got=%0d/%h want=2/9444", fv_cnt - f0, obs_last_digits);
    end
  endtask

  task automatic test_mid_reset();
    int f0;
    f0 = fv_cnt;
    drive_slot(seg_tab[3], 4'b1110, 10);
    drive_slot(seg_tab[8], 4'b1101, 10);
    #2;
    rst_n = 1'b0;
    seg_n = 7'h7F;
    dig_n = 4'hF;
    last_seg = 7'h7F;
    last_dig = 4'hF;
    #1;
    total++;
    if (digits !== 16'hFFFF || digit_err !== 4'h0 || frame_valid !== 1'b0) begin
      bad++; $display("FAIL midreset_outputs got=%h/%b/%b want=ffff/0000/0", digits, digit_err, frame_valid);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    drive_slot(seg_tab[1], 4'b1011, 10);
    drive_slot(seg_tab[2], 4'b0111, 10);
    idle(8);
    total++;
    if (fv_cnt !== f0 || digits !== 16'h21FF) begin
      bad++; $display("FAIL midreset_mask got=%0d/%h want=0/21ff", fv_cnt - f0, digits);
    end
    drive_slot(seg_tab[5], 4'b1110, 10);
    drive_slot(seg_tab[6], 4'b1101, 10);
    idle(8);
    total++;
    if (fv_cnt !== f0 + 1 || obs_last_digits !== 16'h2165) begin
      bad++; $display("FAIL midreset_frame got=%0d/%h want=1/2165", fv_cnt - f0, obs_last_digits);
    end
  endtask

  task automatic test_random();
    logic [6:0] seg;
    logic [3:0] dig;
    int len;
    int sel;
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 6; k++) begin
        sel = int'($urandom_range(0, 99));
        if (sel < 80) begin
          dig = 4'hF;
          dig[$urandom_range(0, 3)] = 1'b0;
        end else begin
          dig = 4'($urandom);
        end
        sel = int'($urandom_range(0, 99));
        if (sel < 70)      seg = seg_tab[$urandom_range(0, 9)];
        else if (sel < 85) seg = 7'h7F;
        else               seg = 7'($urandom);
        while (seg == last_seg && dig == last_dig) seg = 7'($urandom);
        sel = int'($urandom_range(0, 2));
        len = (sel == 0) ? S : (sel == 1) ? S + 1 : 6 + int'($urandom_range(0, 9));
        drive_slot(seg, dig, len);
      end
      idle(8);
      total++;
      if (digits !== pack_digits() || digit_err !== m_err) begin
        bad++; $display("FAIL rand_digits round=%0d got=%h/%b want=%h/%b", r, digits, digit_err, pack_digits(), m_err);
      end
      total++;
      if (fv_cnt !== m_frames) begin
        bad++; $display("FAIL rand_frames round=%0d got=%0d want=%0d", r, fv_cnt, m_frames);
      end
      if (m_frames > 0) begin
        total++;
        if (obs_last_digits !== m_last_digits || obs_last_fe !== m_last_fe) begin
          bad++; $display("FAIL rand_frame_payload round=%0d got=%h/%b want=%h/%b", r, obs_last_digits, obs_last_fe, m_last_digits, m_last_fe);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    seg_n = 7'h7F;
    dig_n = 4'hF;
    @(negedge clk);
    test_reset();
    test_clean_scan();
    test_short_slot();
    test_invalid_blank();
    test_bad_select();
    test_recapture();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
